// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle controller for the MIPS-subset core.
// Sequences each instruction through IF/ID/EX/MEM/WB, gates the PC/IR/RF/memory
// write strobes per state, bounds every memory wait and traps on illegal
// opcodes or memory timeouts.
// Optional build macro: MC_CTRL_PERF_EN adds the cyc_cnt/instr_cnt counters.
module mc_ctrl #(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int PERF_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic [ALUOP_W-1:0] aluop,
    output logic [1:0]         s_num_write,
    output logic [1:0]         s_ext,
    output logic               s_a,
    output logic               s_b,
    output logic [1:0]         s_data_write,
    output logic [1:0]         s_npc,
    output logic [2:0]         state,
    output logic               trap
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0]  cyc_cnt,
    output logic [PERF_W-1:0]  instr_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    typedef enum logic [2:0] {C_ALU, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR} cls_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL = 6'h03,
                           OP_BEQ   = 6'h04, OP_ADDI = 6'h08, OP_ADDIU = 6'h09,
                           OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_LUI = 6'h0F,
                           OP_LW    = 6'h23, OP_SW   = 6'h2B;
    localparam logic [5:0] F_JR  = 6'h08, F_ADD = 6'h20, F_ADDU = 6'h21,
                           F_SUBU = 6'h23, F_AND = 6'h24, F_OR  = 6'h25,
                           F_SLT = 6'h2A;

    // def.v select/ALU encodings shared with the existing datapath muxes
    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(4'h0);
    localparam logic [ALUOP_W-1:0] ALU_ADDU = ALUOP_W'(4'h1);
    localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(4'h4);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(4'h5);
    localparam logic [1:0] N_NPC = 2'd0, J_NPC = 2'd1, JR_NPC = 2'd2, BEQ_NPC = 2'd3;
    localparam logic [1:0] NW_RT = 2'd0, NW_RD = 2'd1, NW_31 = 2'd2;
    localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_LUI = 2'd2;
    localparam logic [1:0] DW_ALU = 2'd0, DW_MEM = 2'd1, DW_NPC = 2'd2;
    localparam logic ALU_A_REG = 1'b0, ALU_A_NPC = 1'b1;
    localparam logic ALU_B_REG = 1'b0, ALU_B_IMM = 1'b1;

    // Wait counter only needs to reach MEM_TIMEOUT-1: the next unready cycle traps.
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state_r, state_nxt;
    cls_t              cls;
    logic              legal;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_expired;

    assign state        = state_r;
    assign wait_expired = (wait_cnt == WAIT_LIMIT) && !mem_ready;

    // Instruction decode: class, legality and all datapath selects from op/funct/zero
    always_comb begin
        legal        = 1'b1;
        cls          = C_ALU;
        aluop        = ALU_ADDU;
        s_num_write  = NW_RT;
        s_ext        = EXT_SIGN;
        s_a          = ALU_A_REG;
        s_b          = ALU_B_IMM;
        s_data_write = DW_ALU;
        s_npc        = N_NPC;
        case (op)
            OP_RTYPE: begin
                s_num_write = NW_RD;
                s_b         = ALU_B_REG;
                aluop       = ALUOP_W'(funct[3:0]);
                case (funct)
                    F_ADD, F_ADDU, F_SUBU, F_AND, F_OR, F_SLT: cls = C_ALU;
                    F_JR: begin
                        cls   = C_JR;
                        s_npc = JR_NPC;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI:  aluop = ALU_ADD;
            OP_ADDIU: aluop = ALU_ADDU;
            OP_ANDI: begin
                aluop = ALU_AND;
                s_ext = EXT_ZERO;
            end
            OP_ORI: begin
                aluop = ALU_OR;
                s_ext = EXT_ZERO;
            end
            OP_LUI: begin
                aluop = ALU_OR;
                s_ext = EXT_LUI;
            end
            OP_LW: begin
                cls          = C_LW;
                s_data_write = DW_MEM;
            end
            OP_SW:  cls = C_SW;
            OP_BEQ: begin
                cls   = C_BEQ;
                s_a   = ALU_A_NPC;
                s_npc = zero ? BEQ_NPC : N_NPC;
            end
            OP_J: begin
                cls   = C_J;
                s_npc = J_NPC;
            end
            OP_JAL: begin
                cls          = C_JAL;
                s_npc        = J_NPC;
                s_num_write  = NW_31;
                s_data_write = DW_NPC;
            end
            default: legal = 1'b0;
        endcase
    end

    // Next-state and per-state strobes; reset masks every strobe so an aborted
    // instruction never writes the PC, IR, register file or memory
    always_comb begin
        state_nxt = state_r;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        trap      = 1'b0;
        case (state_r)
            S_IF: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    state_nxt = S_ID;
                end else if (wait_expired) begin
                    state_nxt = S_TRAP;
                end
            end
            S_ID: begin
                if (!legal) begin
                    state_nxt = S_TRAP;
                end else begin
                    case (cls)
                        C_J: begin
                            pc_write  = 1'b1;
                            state_nxt = S_IF;
                        end
                        C_JAL:   state_nxt = S_WB;
                        default: state_nxt = S_EX;
                    endcase
                end
            end
            S_EX: begin
                case (cls)
                    C_LW, C_SW: state_nxt = S_MEM;
                    C_BEQ, C_JR: begin
                        pc_write  = 1'b1;
                        state_nxt = S_IF;
                    end
                    default: state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (cls == C_SW) mem_write = 1'b1;
                else             mem_read  = 1'b1;
                if (mem_ready) begin
                    if (cls == C_SW) begin
                        pc_write  = 1'b1;
                        state_nxt = S_IF;
                    end else begin
                        state_nxt = S_WB;
                    end
                end else if (wait_expired) begin
                    state_nxt = S_TRAP;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_nxt = S_IF;
            end
            S_TRAP: trap = 1'b1;
            default: state_nxt = S_TRAP;
        endcase
        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_r <= S_IF;
        else     state_r <= state_nxt;
    end

    // Memory wait counter: counts unready IF/MEM cycles, restarts on every state change
    always_ff @(posedge clk) begin
        if (rst || (state_nxt != state_r))
            wait_cnt <= '0;
        else if (((state_r == S_IF) || (state_r == S_MEM)) && !mem_ready)
            wait_cnt <= wait_cnt + 1'b1;
    end

`ifdef MC_CTRL_PERF_EN
    // Performance counters: live cycles outside TRAP, and retired instructions (PC loads)
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt   <= '0;
            instr_cnt <= '0;
        end else begin
            if (state_r != S_TRAP) cyc_cnt <= cyc_cnt + 1'b1;
            if (pc_write)          instr_cnt <= instr_cnt + 1'b1;
        end
    end
`else
    // PERF_W sizes the counters only when they are built.
    if (PERF_W < 1) begin : g_perf_w_unused
    end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed, table-driven bench for mc_ctrl plus hand-written
// sequences for reset, trap and memory-timeout corner cases.
module tb_mc_ctrl;

    logic       clk, rst, zero, mem_ready;
    logic [5:0] op, funct;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write;
    logic [3:0] aluop;
    logic [1:0] s_num_write, s_ext, s_data_write, s_npc;
    logic       s_a, s_b, trap;
    logic [2:0] state;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cyc_cnt, instr_cnt;
    logic [31:0] c0, i0;
`endif

    mc_ctrl #(.ALUOP_W(4), .MEM_TIMEOUT(15), .PERF_W(32)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .aluop(aluop), .s_num_write(s_num_write), .s_ext(s_ext), .s_a(s_a),
        .s_b(s_b), .s_data_write(s_data_write), .s_npc(s_npc),
        .state(state), .trap(trap)
`ifdef MC_CTRL_PERF_EN
        , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath select codes (def.v)
    localparam logic [1:0] N_NPC = 2'd0, J_NPC = 2'd1, JR_NPC = 2'd2, BEQ_NPC = 2'd3;
    localparam logic [1:0] NW_RT = 2'd0, NW_RD = 2'd1, NW_31 = 2'd2;
    localparam logic [1:0] DW_ALU = 2'd0, DW_MEM = 2'd1, DW_NPC = 2'd2;
    localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_LUI = 2'd2;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        int          if_wait;
        int          mem_wait;
        int          cycles;
        logic [31:0] seq;      // one nibble per cycle: state+1
        int          regw;
        int          memw;
        logic [1:0]  npc;
        logic [1:0]  nw;
        logic [1:0]  dw;
        logic        chk_ex;
        logic [3:0]  alu;
        logic        sa;
        logic        sb;
        logic        chk_ext;
        logic [1:0]  ext;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Runs one instruction from the IF negedge until its PC load (or trap / budget).
    task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn, input logic iz,
                             input int ifw, input int mw,
                             output int cyc, output logic [31:0] seq,
                             output int n_pc, output int n_reg, output int n_memw,
                             output logic [1:0] npc, output logic [1:0] nw,
                             output logic [1:0] dw, output logic [1:0] ext,
                             output logic [3:0] alu, output logic sa, output logic sb,
                             output logic trapped, output logic finished);
        int k;
        logic [2:0] prev;
        cyc = 0; seq = 0; n_pc = 0; n_reg = 0; n_memw = 0;
        npc = 0; nw = 0; dw = 0; ext = 0; alu = 0; sa = 0; sb = 0;
        trapped = 1'b0; finished = 1'b0;
        k = 0; prev = 3'd7;
        op = iop; funct = ifn; zero = iz;
        for (int c = 0; c < 60; c++) begin
            if (state != prev) k = 0;
            prev = state;
            if (state == 3'd5) begin
                trapped = 1'b1;
                break;
            end
            mem_ready = (state == 3'd0) ? (k >= ifw) : (state == 3'd3) ? (k >= mw) : 1'b0;
            #1;
            cyc++;
            seq = (seq << 4) | (32'(state) + 32'd1);
            if (state == 3'd2) begin
                alu = aluop; sa = s_a; sb = s_b; ext = s_ext;
            end
            if (reg_write) begin
                n_reg++; nw = s_num_write; dw = s_data_write;
            end
            if (mem_write) n_memw++;
            if (pc_write) begin
                n_pc++; npc = s_npc; finished = 1'b1;
            end
            k++;
            @(negedge clk);
            if (finished) break;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vt[15];
    int cyc, n_pc, n_reg, n_memw;
    logic [31:0] seq;
    logic [1:0] npc, nw, dw, ext;
    logic [3:0] alu;
    logic sa, sb, trapped, finished;

    initial begin
        //             op     fn     z  ifw mw cyc seq           rw mw npc      nw     dw      ex alu   sa sb ce ext
        vt[0]  = '{6'h00, 6'h21, 0, 0, 0, 4, 32'h1235,     1, 0, N_NPC,   NW_RD, DW_ALU, 1, 4'h1, 0, 0, 0, EXT_SIGN};
        vt[1]  = '{6'h00, 6'h23, 0, 0, 0, 4, 32'h1235,     1, 0, N_NPC,   NW_RD, DW_ALU, 1, 4'h3, 0, 0, 0, EXT_SIGN};
        vt[2]  = '{6'h00, 6'h24, 0, 0, 0, 4, 32'h1235,     1, 0, N_NPC,   NW_RD, DW_ALU, 1, 4'h4, 0, 0, 0, EXT_SIGN};
        vt[3]  = '{6'h00, 6'h2A, 0, 0, 0, 4, 32'h1235,     1, 0, N_NPC,   NW_RD, DW_ALU, 1, 4'hA, 0, 0, 0, EXT_SIGN};
        vt[4]  = '{6'h0D, 6'h00, 0, 0, 0, 4, 32'h1235,     1, 0, N_NPC,   NW_RT, DW_ALU, 1, 4'h5, 0, 1, 1, EXT_ZERO};
        vt[5]  = '{6'h0F, 6'h00, 0, 0, 0, 4, 32'h1235,     1, 0, N_NPC,   NW_RT, DW_ALU, 1, 4'h5, 0, 1, 1, EXT_LUI};
        vt[6]  = '{6'h09, 6'h00, 0, 0, 0, 4, 32'h1235,     1, 0, N_NPC,   NW_RT, DW_ALU, 1, 4'h1, 0, 1, 1, EXT_SIGN};
        vt[7]  = '{6'h23, 6'h00, 0, 0, 3, 8, 32'h12344445, 1, 0, N_NPC,   NW_RT, DW_MEM, 1, 4'h1, 0, 1, 1, EXT_SIGN};
        vt[8]  = '{6'h23, 6'h00, 0, 0, 0, 5, 32'h12345,    1, 0, N_NPC,   NW_RT, DW_MEM, 1, 4'h1, 0, 1, 1, EXT_SIGN};
        vt[9]  = '{6'h2B, 6'h00, 0, 0, 2, 6, 32'h123444,   0, 3, N_NPC,   NW_RT, DW_ALU, 1, 4'h1, 0, 1, 1, EXT_SIGN};
        vt[10] = '{6'h04, 6'h00, 1, 0, 0, 3, 32'h123,      0, 0, BEQ_NPC, NW_RT, DW_ALU, 1, 4'h1, 1, 1, 0, EXT_SIGN};
        vt[11] = '{6'h04, 6'h00, 0, 0, 0, 3, 32'h123,      0, 0, N_NPC,   NW_RT, DW_ALU, 1, 4'h1, 1, 1, 0, EXT_SIGN};
        vt[12] = '{6'h02, 6'h00, 0, 0, 0, 2, 32'h12,       0, 0, J_NPC,   NW_RT, DW_ALU, 0, 4'h0, 0, 0, 0, EXT_SIGN};
        vt[13] = '{6'h03, 6'h00, 0, 0, 0, 3, 32'h125,      1, 0, J_NPC,   NW_31, DW_NPC, 0, 4'h0, 0, 0, 0, EXT_SIGN};
        vt[14] = '{6'h00, 6'h08, 0, 2, 0, 5, 32'h11123,    0, 0, JR_NPC,  NW_RT, DW_ALU, 0, 4'h0, 0, 0, 0, EXT_SIGN};

        rst = 1'b1; mem_ready = 1'b0; op = 6'h00; funct = 6'h21; zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("rst.state", state, 3'd0);
        check("rst.trap", trap, 1'b0);
        check("rst.strobes", {pc_write, ir_write, mem_write, reg_write}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("post_rst.strobes", {pc_write, ir_write, mem_write, reg_write}, 4'b0000);
        check("post_rst.mem_read", mem_read, 1'b1);
`ifdef MC_CTRL_PERF_EN
        check("post_rst.cyc_cnt", cyc_cnt, 32'd0);
        check("post_rst.instr_cnt", instr_cnt, 32'd0);
`endif

        // Table of complete instructions
        for (int i = 0; i < 15; i++) begin
`ifdef MC_CTRL_PERF_EN
            c0 = cyc_cnt; i0 = instr_cnt;
`endif
            run_instr(vt[i].op, vt[i].funct, vt[i].zero, vt[i].if_wait, vt[i].mem_wait,
                      cyc, seq, n_pc, n_reg, n_memw, npc, nw, dw, ext, alu, sa, sb,
                      trapped, finished);
            check($sformatf("vec%0d.finished", i), finished, 1'b1);
            check($sformatf("vec%0d.cycles", i), cyc, vt[i].cycles);
            check($sformatf("vec%0d.states", i), seq, vt[i].seq);
            check($sformatf("vec%0d.pc_writes", i), n_pc, 1);
            check($sformatf("vec%0d.reg_writes", i), n_reg, vt[i].regw);
            check($sformatf("vec%0d.mem_writes", i), n_memw, vt[i].memw);
            check($sformatf("vec%0d.s_npc", i), npc, vt[i].npc);
            if (vt[i].regw > 0) begin
                check($sformatf("vec%0d.s_num_write", i), nw, vt[i].nw);
                check($sformatf("vec%0d.s_data_write", i), dw, vt[i].dw);
            end
            if (vt[i].chk_ex) begin
                check($sformatf("vec%0d.aluop", i), alu, vt[i].alu);
                check($sformatf("vec%0d.s_a", i), sa, vt[i].sa);
                check($sformatf("vec%0d.s_b", i), sb, vt[i].sb);
            end
            if (vt[i].chk_ext) check($sformatf("vec%0d.s_ext", i), ext, vt[i].ext);
`ifdef MC_CTRL_PERF_EN
            check($sformatf("vec%0d.cyc_cnt", i), cyc_cnt - c0, vt[i].cycles);
            check($sformatf("vec%0d.instr_cnt", i), instr_cnt - i0, 32'd1);
`endif
        end

        // sw: mem_ready arrives on the 15th MEM cycle -> completes, no trap
        run_instr(6'h2B, 6'h00, 1'b0, 0, 14, cyc, seq, n_pc, n_reg, n_memw,
                  npc, nw, dw, ext, alu, sa, sb, trapped, finished);
        check("sw_ready_at_limit.trapped", trapped, 1'b0);
        check("sw_ready_at_limit.finished", finished, 1'b1);
        check("sw_ready_at_limit.cycles", cyc, 18);
        check("sw_ready_at_limit.mem_writes", n_memw, 15);

        // Illegal funct traps out of ID
        run_instr(6'h00, 6'h3F, 1'b0, 0, 0, cyc, seq, n_pc, n_reg, n_memw,
                  npc, nw, dw, ext, alu, sa, sb, trapped, finished);
        check("bad_funct.trapped", trapped, 1'b1);
        check("bad_funct.cycles", cyc, 2);
        check("bad_funct.trap", trap, 1'b1);
        pulse_reset();
        #1;
        check("bad_funct.rst_state", state, 3'd0);

        // Reset while in WB: no strobes, back to IF
        op = 6'h00; funct = 6'h21; mem_ready = 1'b1;
        for (int c = 0; c < 10 && state != 3'd4; c++) @(negedge clk);
        check("midrst.reach_wb", state, 3'd4);
        rst = 1'b1;
        #1;
        check("midrst.pc_write", pc_write, 1'b0);
        check("midrst.reg_write", reg_write, 1'b0);
        @(negedge clk);
        rst = 1'b0; mem_ready = 1'b0;
        #1;
        check("midrst.state", state, 3'd0);
        check("midrst.strobes", {pc_write, ir_write, mem_write, reg_write}, 4'b0000);
`ifdef MC_CTRL_PERF_EN
        check("midrst.instr_cnt", instr_cnt, 32'd0);
`endif

        // Illegal opcode 0x3F: IF -> ID -> TRAP, sticky
        op = 6'h3F; funct = 6'h00; mem_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bad_op.id_state", state, 3'd1);
        @(negedge clk);
        #1;
        check("bad_op.state", state, 3'd5);
        check("bad_op.trap", trap, 1'b1);
        check("bad_op.strobes", {pc_write, ir_write, mem_write, reg_write, mem_read}, 5'b00000);
`ifdef MC_CTRL_PERF_EN
        c0 = cyc_cnt;
`endif
        repeat (3) @(negedge clk);
        #1;
        check("bad_op.sticky", state, 3'd5);
`ifdef MC_CTRL_PERF_EN
        check("bad_op.cyc_frozen", cyc_cnt, c0);
`endif
        pulse_reset();
        #1;
        check("bad_op.rst_trap", trap, 1'b0);

        // sw with mem_ready stuck low: 15 unready MEM cycles -> TRAP, then reset
        run_instr(6'h2B, 6'h00, 1'b0, 0, 1000, cyc, seq, n_pc, n_reg, n_memw,
                  npc, nw, dw, ext, alu, sa, sb, trapped, finished);
        check("sw_timeout.trapped", trapped, 1'b1);
        check("sw_timeout.cycles", cyc, 18);
        check("sw_timeout.pc_writes", n_pc, 0);
        #1;
        check("sw_timeout.state", state, 3'd5);
        check("sw_timeout.trap", trap, 1'b1);
        check("sw_timeout.mem_write", mem_write, 1'b0);
        mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("sw_timeout.rst_strobes", {pc_write, ir_write, mem_write, reg_write}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("sw_timeout.rst_state", state, 3'd0);
        check("sw_timeout.rst_trap", trap, 1'b0);
        check("sw_timeout.post_strobes", {pc_write, ir_write, mem_write, reg_write}, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multi-cycle controller for the MIPS-subset core, replacing the single-cycle controller.
- FSM sequences each instruction through IF/ID/EX/MEM/WB and gates PC, IR, register-file and memory writes per state.
- Memory accesses use a ready handshake with a bounded wait; timeouts and illegal opcodes enter a sticky TRAP state.
- Datapath select encodings are unchanged from def.v, so the existing datapath muxes are reused.

Parameters:
- ALUOP_W, 4, width of aluop.
- MEM_TIMEOUT, 15, maximum wait cycles for mem_ready per access (>=1); exceeding it traps.
- PERF_W, 32, width of performance counters (used only with MC_CTRL_PERF_EN).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag; sampled in EX
- mem_ready  in  1  memory completes current access this cycle
- pc_write  out  1  PC load strobe
- ir_write  out  1  IR load strobe
- mem_read  out  1  memory read request (instruction fetch or lw)
- mem_write  out  1  memory write request (sw)
- reg_write  out  1  register-file write strobe
- aluop  out  ALUOP_W  ALU operation (def.v codes)
- s_num_write  out  2  write-register select
- s_ext  out  2  extender mode
- s_a  out  1  ALU A select
- s_b  out  1  ALU B select (0 = reg, 1 = imm)
- s_data_write  out  2  write-data select
- s_npc  out  2  next-PC select
- state  out  3  current FSM state
- trap  out  1  high while in TRAP
- cyc_cnt, instr_cnt  out  PERF_W  present only with MC_CTRL_PERF_EN

Behaviour:
- Single clock domain. Reset is synchronous and active-high: rst=1 at a rising clk edge loads state=IF, clears the wait counter and trap, and clears the perf counters.
- During rst and immediately after it, every strobe (pc_write, ir_write, mem_write, reg_write) is 0.
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=5.
- Outputs are combinational from state, op, funct and zero. Registered state only.
- Select outputs are don't-care outside the states that use them, but must hold the values listed below.
- IF: mem_read=1. On mem_ready: ir_write=1 for that one cycle and next state is ID. Otherwise stay in IF.
- ID: decode op/funct. Next-state rules:
  - Illegal op/funct -> TRAP.
  - J -> pc_write=1, s_npc=J_nPC, next state IF.
  - JAL -> WB.
  - All other legal instructions -> EX.
- EX: aluop, s_a, s_b and s_ext follow the single-cycle decode. Exception: LUI writes rt.
  - R-type ALU ops (ADD/ADDU/SUBU/AND/OR/SLT) use aluop=funct[3:0].
  - R-type and immediate ALU ops -> WB.
  - LW/SW -> MEM.
  - BEQ: s_a=ALU_a_nPC, pc_write=1, s_npc = zero ? BEQ_nPC : N_nPC, next state IF.
  - JR: pc_write=1, s_npc=JR_nPC, next state IF.
- MEM:
  - LW: mem_read=1; on mem_ready -> WB.
  - SW: mem_write=1 held until mem_ready; on mem_ready, pc_write=1, s_npc=N_nPC, next state IF.
- WB: reg_write=1 for exactly one cycle and pc_write=1 (s_npc=N_nPC), next state IF.
  - s_data_write = MEM for LW, nPC for JAL, ALU otherwise.
  - s_num_write = rd for R-type, 31 for JAL, rt otherwise.
  - JAL uses s_npc=J_nPC.
- Latency in cycles with zero memory wait: J=2, BEQ/JR=3, JAL=3, ALU=4, SW=4, LW=5. Each memory wait cycle adds 1.
- Wait counter:
  - Increments each cycle in IF or MEM while mem_ready=0, and clears when the state changes.
  - Reaching MEM_TIMEOUT with mem_ready=0 -> TRAP.
  - mem_ready=1 in the same cycle as the timeout wins, so no trap.
- TRAP: all strobes 0, trap=1. Exits only via rst.
- A reset asserted mid-instruction aborts it: the PC is not written and state returns to IF.

Optional Feature:
MC_CTRL_PERF_EN
- Defined: cyc_cnt increments every cycle outside TRAP; instr_cnt increments on every pc_write. Both wrap modulo 2^PERF_W and clear on rst.
- Undefined: both ports and counters are absent and the FSM behaviour is identical.

Test Plan:
- addu (op=0, funct=0x21), mem_ready=1 immediately -> IF,ID,EX,WB states; reg_write=1 only in WB with s_num_write=rd, aluop=1; pc_write exactly once.
- lw (op=0x23) with 3 wait cycles in MEM -> 8 cycles total; reg_write in WB with s_data_write=MEM; mem_write never asserted.
- beq (op=0x04) with zero=1, then with zero=0 -> pc_write in EX with s_npc=BEQ_nPC, then N_nPC; reg_write stays 0.
- jal (op=0x03) -> WB has reg_write=1, s_num_write=31, s_data_write=nPC, s_npc=J_nPC; 3 cycles.
- sw with mem_ready held 0 for 15 cycles -> trap=1, state=5; then rst=1 for one cycle -> state=0, trap=0, no strobes.
- op=0x3F -> TRAP from ID. Same case with MEM_TIMEOUT=15 and mem_ready=1 arriving on the 15th wait cycle -> no trap.
- With MC_CTRL_PERF_EN: cyc_cnt and instr_cnt are checked against the counts above.
